// File: rtl/mem_access_arbiter.sv
// Two-port round-robin arbiter that serializes single read or read-modify-write
// transactions onto the shared memory-system bus and counts completions.
module mem_access_arbiter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             reqA,
  input  logic             wrA,
  input  logic [2:0]       addrA,
  input  logic [1:0]       opA,
  input  logic [7:0]       dataA,
  output logic             ackA,
  input  logic             reqB,
  input  logic             wrB,
  input  logic [2:0]       addrB,
  input  logic [1:0]       opB,
  input  logic [7:0]       dataB,
  output logic             ackB,
  output logic             memMode,
  output logic [2:0]       memAddr,
  output logic [1:0]       memOp,
  output logic [7:0]       memDataIn,
  input  logic [7:0]       memDataOut,
  output logic [7:0]       rdData,
  output logic             busy,
  output logic [CNT_W-1:0] txCount
);

  typedef enum logic [1:0] {StIdle, StIssue, StResp, StAck} state_e;

  state_e           state_q;
  logic             ptr_q;    // 0: A has priority, 1: B has priority
  logic             gnt_q;    // 0: A granted, 1: B granted
  logic             wr_q;
  logic [2:0]       addr_q;
  logic [1:0]       op_q;
  logic [7:0]       data_q;
  logic [7:0]       rd_q;
  logic             ack_a_q;
  logic             ack_b_q;
  logic [CNT_W-1:0] cnt_q;

  logic             any_req;
  logic             pick_b;

  always_comb begin
    any_req = reqA | reqB;
    pick_b  = reqB & (~reqA | ptr_q);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= StIdle;
      ptr_q   <= 1'b0;
      gnt_q   <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      op_q    <= '0;
      data_q  <= '0;
      rd_q    <= '0;
      ack_a_q <= 1'b0;
      ack_b_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (any_req) begin
            gnt_q   <= pick_b;
            ptr_q   <= ~pick_b;
            wr_q    <= pick_b ? wrB   : wrA;
            addr_q  <= pick_b ? addrB : addrA;
            op_q    <= pick_b ? opB   : opA;
            data_q  <= pick_b ? dataB : dataA;
            state_q <= StIssue;
          end
        end
        StIssue: state_q <= StResp;
        StResp: begin
          // In-place write has already committed, so this returns the new value.
          rd_q    <= memDataOut;
          ack_a_q <= ~gnt_q;
          ack_b_q <= gnt_q;
          state_q <= StAck;
        end
        StAck: begin
          ack_a_q <= 1'b0;
          ack_b_q <= 1'b0;
          cnt_q   <= cnt_q + CNT_W'(1);
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Only an ISSUE cycle of a write may drive write mode into the RAM.
  always_comb begin
    memMode   = ~((state_q == StIssue) & wr_q);
    memAddr   = addr_q;
    memOp     = op_q;
    memDataIn = data_q;
    busy      = (state_q != StIdle);
    ackA      = ack_a_q;
    ackB      = ack_b_q;
    rdData    = rd_q;
    txCount   = cnt_q;
  end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Bench for mem_access_arbiter with a behavioural RAM/ROM memory system model and
// a second counter-width-2 instance sharing the same stimulus.
module tb_mem_access_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       reqA, wrA, reqB, wrB;
  logic [2:0] addrA, addrB;
  logic [1:0] opA, opB;
  logic [7:0] dataA, dataB;
  logic       ackA, ackB, memMode, busy;
  logic [2:0] memAddr;
  logic [1:0] memOp;
  logic [7:0] memDataIn, memDataOut, rdData;
  logic [7:0] txCount;
  logic       ackA2, ackB2, memMode2, busy2;
  logic [2:0] memAddr2;
  logic [1:0] memOp2;
  logic [7:0] memDataIn2, rdData2;
  logic [1:0] txCount2;

  always #5 clk = ~clk;

  mem_access_arbiter #(.CNT_W(8)) dut (
    .CLK(clk), .RST_N(rst_n),
    .reqA(reqA), .wrA(wrA), .addrA(addrA), .opA(opA), .dataA(dataA), .ackA(ackA),
    .reqB(reqB), .wrB(wrB), .addrB(addrB), .opB(opB), .dataB(dataB), .ackB(ackB),
    .memMode(memMode), .memAddr(memAddr), .memOp(memOp), .memDataIn(memDataIn),
    .memDataOut(memDataOut), .rdData(rdData), .busy(busy), .txCount(txCount)
  );

  mem_access_arbiter #(.CNT_W(2)) dut2 (
    .CLK(clk), .RST_N(rst_n),
    .reqA(reqA), .wrA(wrA), .addrA(addrA), .opA(opA), .dataA(dataA), .ackA(ackA2),
    .reqB(reqB), .wrB(wrB), .addrB(addrB), .opB(opB), .dataB(dataB), .ackB(ackB2),
    .memMode(memMode2), .memAddr(memAddr2), .memOp(memOp2), .memDataIn(memDataIn2),
    .memDataOut(memDataOut), .rdData(rdData2), .busy(busy2), .txCount(txCount2)
  );

  // Memory system model: ROM-op-dataIn written into RAM on a write-mode edge.
  logic [7:0] ram [8];
  logic [7:0] rom [8];

  function automatic logic [7:0] alu(input logic [7:0] a, input logic [1:0] op,
                                     input logic [7:0] b);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~(a & b);
    endcase
  endfunction

  assign memDataOut = ram[memAddr];
  always @(posedge clk) if (!memMode) ram[memAddr] <= alu(rom[memAddr], memOp, memDataIn);

  typedef struct {
    logic       sel;   // 0 = A, 1 = B
    logic       wr;
    logic [2:0] addr;
    logic [1:0] op;
    logic [7:0] data;
    logic [7:0] rd;
  } vec_t;

  typedef struct {
    logic       sel;
    logic [7:0] rd;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   exp_cnt = 0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endfunction

  task automatic idle_inputs();
    reqA = 0; wrA = 0; addrA = 0; opA = 0; dataA = 0;
    reqB = 0; wrB = 0; addrB = 0; opB = 0; dataB = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 0;
    sb.delete();
  endtask

  task automatic drive(input vec_t v);
    if (!v.sel) begin
      reqA = 1; wrA = v.wr; addrA = v.addr; opA = v.op; dataA = v.data;
    end else begin
      reqB = 1; wrB = v.wr; addrB = v.addr; opB = v.op; dataB = v.data;
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after the ack.
  task automatic do_txn(input vec_t v);
    exp_t e;
    int   lat = 0;
    drive(v);
    sb.push_back('{sel: v.sel, rd: v.rd});
    for (int i = 1; i <= 10 && lat == 0; i++) begin
      @(negedge clk);
      if (ackA || ackB) lat = i;
    end
    check("ack_latency", lat, 3);
    e = sb.pop_front();
    if (lat != 0) begin
      check("ack_side", {ackA, ackB}, e.sel ? 2'b01 : 2'b10);
      check("rdData", rdData, e.rd);
      idle_inputs();
      @(negedge clk);
      exp_cnt++;
      check("ack_width", {ackA, ackB}, 2'b00);
      check("txCount", txCount, exp_cnt[7:0]);
      check("txCount_w2", txCount2, exp_cnt[1:0]);
    end else begin
      idle_inputs();
    end
  endtask

  vec_t vecs[14];

  initial begin
    int acks;
    int last_ack;
    exp_t e;

    rom = '{8'h11, 8'h5A, 8'h3C, 8'h23, 8'hC4, 8'h65, 8'h9E, 8'h45};
    foreach (ram[i]) ram[i] = 8'h00;

    for (int i = 0; i < 8; i++)
      vecs[i] = '{sel: 1'b1, wr: 1'b0, addr: 3'(i), op: 2'b00, data: 8'h00, rd: 8'h00};
    vecs[8]  = '{sel: 1'b0, wr: 1'b1, addr: 3'd3, op: 2'b10, data: 8'hFF, rd: 8'hDC};
    vecs[9]  = '{sel: 1'b1, wr: 1'b0, addr: 3'd3, op: 2'b00, data: 8'h00, rd: 8'hDC};
    vecs[10] = '{sel: 1'b0, wr: 1'b1, addr: 3'd4, op: 2'b11, data: 8'h0F, rd: 8'hFB};
    vecs[11] = '{sel: 1'b0, wr: 1'b1, addr: 3'd7, op: 2'b00, data: 8'hFF, rd: 8'h45};
    vecs[12] = '{sel: 1'b1, wr: 1'b0, addr: 3'd4, op: 2'b00, data: 8'h00, rd: 8'hFB};
    vecs[13] = '{sel: 1'b0, wr: 1'b0, addr: 3'd7, op: 2'b00, data: 8'h00, rd: 8'h45};

    do_reset();
    check("rst_ack", {ackA, ackB}, 2'b00);
    check("rst_rdData", rdData, 8'h00);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_memMode", memMode, 1'b1);
      check("idle_busy", busy, 1'b0);
      check("idle_txCount", txCount, 8'h00);
    end

    foreach (vecs[i]) do_txn(vecs[i]);

    // Both requesters held: grants must alternate A, B, A, B every 4 cycles.
    do_reset();
    reqA = 1; wrA = 0; addrA = 3'd3;
    reqB = 1; wrB = 0; addrB = 3'd4;
    for (int k = 0; k < 4; k++)
      sb.push_back('{sel: k[0], rd: k[0] ? 8'hFB : 8'hDC});
    acks = 0;
    last_ack = -1;
    for (int i = 0; i < 40 && acks < 4; i++) begin
      @(negedge clk);
      if (ackA || ackB) begin
        e = sb.pop_front();
        check("rr_ack_side", {ackA, ackB}, e.sel ? 2'b01 : 2'b10);
        check("rr_rdData", rdData, e.rd);
        if (last_ack >= 0) check("rr_spacing", i - last_ack, 4);
        last_ack = i;
        acks++;
        if (acks == 4) idle_inputs();
      end
    end
    check("rr_ack_count", acks, 4);
    @(negedge clk);
    check("rr_ack_width", {ackA, ackB}, 2'b00);
    check("rr_txCount", txCount, 8'd4);
    check("rr_txCount_w2", txCount2, 2'd0);

    // Reset during RESP of a B write: no ack, but the write stays committed.
    do_reset();
    reqB = 1; wrB = 1; addrB = 3'd5; opB = 2'b01; dataB = 8'hAA;
    @(negedge clk);
    check("mid_issue_mode", memMode, 1'b0);
    @(negedge clk);
    check("mid_resp_mode", memMode, 1'b1);
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    check("mid_ackB", ackB, 1'b0);
    check("mid_busy", busy, 1'b0);
    check("mid_txCount", txCount, 8'h00);
    rst_n = 1'b1;
    exp_cnt = 0;
    do_txn('{sel: 1'b0, wr: 1'b0, addr: 3'd5, op: 2'b00, data: 8'h00, rd: 8'hEF});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
